vedic_mult_pipe: RTL

- Parametrised, fully pipelined Vedic (Urdhva-Tiryagbhyam) NxN multiplier, built recursively from 2x2 Vedic cells and registered adder/buffer stages.
- Adds the following:
  - per-beat signed/unsigned mode;
  - valid/ready handshake with per-stage backpressure and bubble collapsing;
  - a sideband tag that travels with each beat;
  - an occupancy count.
- Sits between the operand fetch logic and the systolic-array accumulators, and serves as their multiply primitive.

---
 rtl/vedic_mult_pipe.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/vedic_mult_pipe.sv
// rtl/vedic_mult_pipe.sv - pipelined recursive Vedic NxN multiplier with handshake, tag and occupancy
module vedic_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WIDTH-1:0]                      a,
  input  logic [WIDTH-1:0]                      b,
  input  logic                                  in_signed,
  input  logic [TAG_W-1:0]                      in_tag,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [2*WIDTH-1:0]                    result,
  output logic [TAG_W-1:0]                      out_tag,
  output logic [$clog2(2*$clog2(WIDTH)+1)-1:0]  occ
);

  localparam int LOG = $clog2(WIDTH);
  localparam int LAT = 2 * LOG;
  localparam int PW  = WIDTH * WIDTH;

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("vedic_mult_pipe: WIDTH must be a power of 2 and >= 2");
  end

  logic [LAT:1]     v;
  logic [LAT:1]     en;
  logic [LAT-1:1]   neg_r;
  logic [TAG_W-1:0] tag_r [1:LAT];
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             neg_in;
  logic             accept, out_fire;
  logic [PW-1:0]    prod_lvl [1:LOG];

  // A stage may load when it or any stage after it holds a bubble, or the sink drains.
  always_comb begin
    en = '0;
    for (int s = 1; s <= LAT; s++) begin
      en[s] = out_ready;
      for (int k = s; k <= LAT; k++) begin
        if (!v[k]) en[s] = 1'b1;
      end
    end
  end

  always_comb begin
    mag_a  = (in_signed && a[WIDTH-1]) ? -a : a;
    mag_b  = (in_signed && b[WIDTH-1]) ? -b : b;
    neg_in = in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
  end

  assign in_ready  = reset & en[1];
  assign accept    = in_valid & in_ready;
  assign out_fire  = v[LAT] & out_ready;
  assign out_valid = v[LAT];
  assign out_tag   = tag_r[LAT];
  assign result    = prod_lvl[LOG][2*WIDTH-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v     <= '0;
      neg_r <= '0;
      occ   <= '0;
      for (int s = 1; s <= LAT; s++) tag_r[s] <= '0;
    end else begin
      if (en[1]) begin
        v[1]     <= accept;
        neg_r[1] <= neg_in;
        tag_r[1] <= in_tag;
      end
      for (int s = 2; s <= LAT; s++) begin
        if (en[s]) begin
          v[s]     <= v[s-1];
          tag_r[s] <= tag_r[s-1];
        end
      end
      for (int s = 2; s <= LAT - 1; s++) begin
        if (en[s]) neg_r[s] <= neg_r[s-1];
      end
      case ({accept, out_fire})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Level L owns stages 2L-1 and 2L and produces all N x N chunk products, N = 2^L.
  for (genvar L = 1; L <= LOG; L++) begin : g_lvl
    localparam int N  = 2 ** L;
    localparam int M  = N / 2;
    localparam int C  = WIDTH / N;
    localparam int P  = C * C;
    localparam int PN = 2 * N;
    localparam int SW = 2 * M;
    localparam int CP = 2 * C;

    logic [P*PN-1:0] prod_d, prod_q;

    if (L == 1) begin : g_cell
      logic [P-1:0] p00, p11, cs, cc;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          p00 <= '0;
          p11 <= '0;
          cs  <= '0;
          cc  <= '0;
        end else if (en[1]) begin
          for (int i = 0; i < C; i++) begin
            for (int j = 0; j < C; j++) begin
              p00[i*C+j] <= mag_a[2*i] & mag_b[2*j];
              p11[i*C+j] <= mag_a[2*i+1] & mag_b[2*j+1];
              cs[i*C+j]  <= (mag_a[2*i+1] & mag_b[2*j]) ^ (mag_a[2*i] & mag_b[2*j+1]);
              cc[i*C+j]  <= (mag_a[2*i+1] & mag_b[2*j]) & (mag_a[2*i] & mag_b[2*j+1]);
            end
          end
        end
      end

      always_comb begin
        prod_d = '0;
        for (int k = 0; k < P; k++) begin
          prod_d[k*4 +: 4] = {p11[k] & cc[k], p11[k] ^ cc[k], cs[k], p00[k]};
        end
      end
    end else begin : g_comb
      logic [P*SW-1:0]     ll, hh;
      logic [P*(SW+1)-1:0] mid;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ll  <= '0;
          hh  <= '0;
          mid <= '0;
        end else if (en[2*L-1]) begin
          for (int i = 0; i < C; i++) begin
            for (int j = 0; j < C; j++) begin
              ll[(i*C+j)*SW +: SW] <= prod_lvl[L-1][((2*i)*CP + 2*j)*SW +: SW];
              hh[(i*C+j)*SW +: SW] <= prod_lvl[L-1][((2*i+1)*CP + 2*j+1)*SW +: SW];
              mid[(i*C+j)*(SW+1) +: SW+1] <=
                {1'b0, prod_lvl[L-1][((2*i+1)*CP + 2*j)*SW +: SW]} +
                {1'b0, prod_lvl[L-1][((2*i)*CP + 2*j+1)*SW +: SW]};
            end
          end
        end
      end

      always_comb begin
        prod_d = '0;
        for (int k = 0; k < P; k++) begin
          prod_d[k*PN +: PN] = {hh[k*SW +: SW], ll[k*SW +: SW]} +
                               (PN'(mid[k*(SW+1) +: SW+1]) << M);
        end
      end
    end

    // The last level restores the sign, so the core only ever sees magnitudes.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        prod_q <= '0;
      end else if (en[2*L]) begin
        prod_q <= (L == LOG && neg_r[LAT-1]) ? -prod_d : prod_d;
      end
    end

    assign prod_lvl[L] = PW'(prod_q);
  end

endmodule
